// File: rtl/code_lock_core_if.sv
// Key-event bus between the keypad scanner and the lock-decision core.
// The scanner drives a one-cycle key_valid strobe alongside a 4-bit key_code.
interface code_lock_core_if;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (output key_valid, output key_code);
    modport slave  (input  key_valid, input  key_code);
endinterface

// File: rtl/code_lock_core.sv
// Lock-decision engine: buffers a DIGITS-long key entry, checks it against a
// programmable user code or a fixed admin code, counts consecutive failures,
// enforces a timed lockout and holds the lock open for a timed window.
module code_lock_core #(
    parameter int unsigned         DIGITS         = 6,
    parameter logic [DIGITS*4-1:0] USER_CODE_INIT = 24'h123456,
    parameter logic [DIGITS*4-1:0] ADMIN_CODE     = 24'h666666,
    parameter int unsigned         MAX_ATTEMPTS   = 3,
    parameter logic [23:0]         OPEN_CYCLES    = 24'd12000000,
    parameter logic [23:0]         LOCKOUT_CYCLES = 24'd12000000
) (
    input  logic                   hwclk,
    input  logic                   reset,
    code_lock_core_if.slave        keys,
    output logic                   unlocked,
    output logic                   fail_pulse,
    output logic                   locked_out,
    output logic                   prog_mode,
    output logic                   code_updated,
    output logic [3:0]             digit_count,
    output logic [3:0]             attempts_left
);

    localparam int unsigned W          = DIGITS * 4;
    localparam logic [3:0]  DIG        = 4'(DIGITS);
    localparam logic [3:0]  DIG_OVF    = 4'(DIGITS + 1);
    localparam logic [3:0]  MAX_A      = 4'(MAX_ATTEMPTS);
    localparam logic [23:0] OPEN_LAST  = OPEN_CYCLES - 24'd1;
    localparam logic [23:0] LOCK_LAST  = LOCKOUT_CYCLES - 24'd1;

    localparam logic [3:0]  KEY_CLEAR  = 4'd10;
    localparam logic [3:0]  KEY_ENTER  = 4'd11;
    localparam logic [3:0]  KEY_MODE   = 4'd12;

    typedef enum logic [2:0] {
        IDLE, CHECK, OPEN, LOCKOUT, PROG_AUTH, PROG_CHECK, PROG_NEW
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  buffer, buffer_nx;
    logic [3:0]    count_nx;
    logic          overflow, overflow_nx;
    logic [3:0]    fail_count, fail_count_nx;
    logic [W-1:0]  user_code, user_code_nx;
    logic [23:0]   timer, timer_nx;
    logic          fail_pulse_nx;
    logic          code_updated_nx;

    logic          is_digit, is_clear, is_enter, is_mode;
    logic          entry_state, entry_ok;
    logic [W+3:0]  shifted;

    assign is_digit    = keys.key_valid && (keys.key_code <= 4'd9);
    assign is_clear    = keys.key_valid && (keys.key_code == KEY_CLEAR);
    assign is_enter    = keys.key_valid && (keys.key_code == KEY_ENTER);
    assign is_mode     = keys.key_valid && (keys.key_code == KEY_MODE);
    assign entry_state = (state == IDLE) || (state == PROG_AUTH) || (state == PROG_NEW);
    // Oldest digit falls off the top; written this way so DIGITS=1 needs no special case.
    assign shifted     = {buffer, keys.key_code};
    assign entry_ok    = (digit_count == DIG) && !overflow;

    // Next-state and next-value logic for the FSM and its datapath.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_nx        = state;
        buffer_nx       = buffer;
        count_nx        = digit_count;
        overflow_nx     = overflow;
        fail_count_nx   = fail_count;
        user_code_nx    = user_code;
        timer_nx        = timer;
        fail_pulse_nx   = 1'b0;
        code_updated_nx = 1'b0;

        if (entry_state) begin
            if (is_digit) begin
                buffer_nx = shifted[W-1:0];
                if (digit_count >= DIG) begin
                    overflow_nx = 1'b1;
                    count_nx    = DIG_OVF;
                end else begin
                    count_nx = digit_count + 4'd1;
                end
            end else if (is_clear) begin
                buffer_nx   = '0;
                count_nx    = '0;
                overflow_nx = 1'b0;
            end
        end

        case (state)
            IDLE: begin
                if (is_enter) begin
                    state_nx = CHECK;
                end else if (is_mode && (digit_count == 4'd0)) begin
                    state_nx = PROG_AUTH;
                end
            end

            CHECK, PROG_CHECK: begin
                buffer_nx   = '0;
                count_nx    = '0;
                overflow_nx = 1'b0;
                if (entry_ok && (buffer == ((state == CHECK) ? user_code : ADMIN_CODE))) begin
                    fail_count_nx = '0;
                    timer_nx      = '0;
                    state_nx      = (state == CHECK) ? OPEN : PROG_NEW;
                end else begin
                    fail_pulse_nx = 1'b1;
                    fail_count_nx = fail_count + 4'd1;
                    timer_nx      = '0;
                    state_nx      = ((fail_count + 4'd1) >= MAX_A) ? LOCKOUT : IDLE;
                end
            end

            OPEN: begin
                // Timer expiry wins over a simultaneous key.
                if (timer == OPEN_LAST) begin
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer + 24'd1;
                    if (is_enter) begin
                        state_nx = IDLE;
                    end
                end
            end

            LOCKOUT: begin
                if (timer == LOCK_LAST) begin
                    state_nx      = IDLE;
                    fail_count_nx = '0;
                end else begin
                    timer_nx = timer + 24'd1;
                end
            end

            PROG_AUTH: begin
                if (is_enter) begin
                    state_nx = PROG_CHECK;
                end else if (is_mode) begin
                    state_nx    = IDLE;
                    buffer_nx   = '0;
                    count_nx    = '0;
                    overflow_nx = 1'b0;
                end
            end

            PROG_NEW: begin
                if (is_enter || is_mode) begin
                    state_nx    = IDLE;
                    buffer_nx   = '0;
                    count_nx    = '0;
                    overflow_nx = 1'b0;
                    if (is_enter) begin
                        if (entry_ok) begin
                            user_code_nx    = buffer;
                            code_updated_nx = 1'b1;
                        end else begin
                            fail_pulse_nx = 1'b1;
                        end
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge hwclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state        <= IDLE;
            buffer       <= '0;
            digit_count  <= '0;
            overflow     <= 1'b0;
            fail_count   <= '0;
            user_code    <= USER_CODE_INIT;
            timer        <= '0;
            fail_pulse   <= 1'b0;
            code_updated <= 1'b0;
        end else begin
            state        <= state_nx;
            buffer       <= buffer_nx;
            digit_count  <= count_nx;
            overflow     <= overflow_nx;
            fail_count   <= fail_count_nx;
            user_code    <= user_code_nx;
            timer        <= timer_nx;
            fail_pulse   <= fail_pulse_nx;
            code_updated <= code_updated_nx;
        end
    end

    assign unlocked      = (state == OPEN);
    assign locked_out    = (state == LOCKOUT);
    assign prog_mode     = (state == PROG_AUTH) || (state == PROG_NEW);
    assign attempts_left = MAX_A - fail_count;

endmodule

// File: tb/tb_code_lock_core.sv
// Directed bench for code_lock_core with DIGITS=4, codes 1234/6666,
// three attempts, 8-cycle open window and 16-cycle lockout.
module tb_code_lock_core;

    localparam logic [3:0] K_CLEAR = 4'd10;
    localparam logic [3:0] K_ENTER = 4'd11;
    localparam logic [3:0] K_MODE  = 4'd12;

    logic       hwclk;
    logic       reset;
    logic       unlocked, fail_pulse, locked_out, prog_mode, code_updated;
    logic [3:0] digit_count, attempts_left;

    int checks = 0;
    int errors = 0;

    code_lock_core_if kbus ();

    code_lock_core #(
        .DIGITS         (4),
        .USER_CODE_INIT (16'h1234),
        .ADMIN_CODE     (16'h6666),
        .MAX_ATTEMPTS   (3),
        .OPEN_CYCLES    (24'd8),
        .LOCKOUT_CYCLES (24'd16)
    ) dut (
        .hwclk         (hwclk),
        .reset         (reset),
        .keys          (kbus),
        .unlocked      (unlocked),
        .fail_pulse    (fail_pulse),
        .locked_out    (locked_out),
        .prog_mode     (prog_mode),
        .code_updated  (code_updated),
        .digit_count   (digit_count),
        .attempts_left (attempts_left)
    );

    // Free-running clock.
    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    // Hard stop in case anything hangs.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge hwclk);
    endtask

    // One-cycle key strobe; returns at the negedge after the sampling edge.
    task automatic press(input logic [3:0] k);
        @(negedge hwclk);
        kbus.key_valid = 1'b1;
        kbus.key_code  = k;
        @(negedge hwclk);
        kbus.key_valid = 1'b0;
        kbus.key_code  = 4'd0;
    endtask

    // Press n hex digits of value, most significant first.
    task automatic press_code(input logic [31:0] value, input int n);
        logic [31:0] v;
        v = value;
        for (int i = n - 1; i >= 0; i--) begin
            press(v[i*4 +: 4]);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge hwclk);
        reset          = 1'b1;
        kbus.key_valid = 1'b0;
        @(negedge hwclk);
        check({tag, "_unlocked"},   {31'd0, unlocked},     32'd0);
        check({tag, "_locked_out"}, {31'd0, locked_out},   32'd0);
        check({tag, "_prog_mode"},  {31'd0, prog_mode},    32'd0);
        check({tag, "_fail_pulse"}, {31'd0, fail_pulse},   32'd0);
        check({tag, "_updated"},    {31'd0, code_updated}, 32'd0);
        check({tag, "_count"},      {28'd0, digit_count},  32'd0);
        check({tag, "_attempts"},   {28'd0, attempts_left}, 32'd3);
        reset = 1'b0;
    endtask

    // Count consecutive cycles unlocked stays high, starting from an already-high sample.
    task automatic measure_open(output int cycles);
        cycles = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!unlocked) break;
            cycles++;
        end
    endtask

    int          open_len;
    int          lock_len;
    logic        saw_unlock;
    logic [3:0]  lock_keys [5];

    initial begin
        reset          = 1'b0;
        kbus.key_valid = 1'b0;
        kbus.key_code  = 4'd0;
        do_reset("rst0");

        // Correct code opens for 8 cycles.
        press_code(32'h1234, 4);
        check("t1_count4", {28'd0, digit_count}, 32'd4);
        press(K_ENTER);
        check("t1_check_state", {31'd0, unlocked}, 32'd0);
        tick();
        check("t1_unlocked", {31'd0, unlocked}, 32'd1);
        measure_open(open_len);
        check("t1_open_len", open_len, 32'd8);
        check("t1_count0", {28'd0, digit_count}, 32'd0);
        check("t1_attempts", {28'd0, attempts_left}, 32'd3);

        // Three wrong codes lead to a 16-cycle lockout that ignores keys.
        for (int a = 0; a < 3; a++) begin
            press_code(32'h1235, 4);
            press(K_ENTER);
            tick();
            check($sformatf("t2_fail%0d", a), {31'd0, fail_pulse}, 32'd1);
            check($sformatf("t2_att%0d", a), {28'd0, attempts_left}, 32'(2 - a));
        end
        check("t2_locked", {31'd0, locked_out}, 32'd1);
        lock_keys[0] = 4'd1; lock_keys[1] = 4'd2; lock_keys[2] = 4'd3;
        lock_keys[3] = 4'd4; lock_keys[4] = K_ENTER;
        lock_len   = 1;
        saw_unlock = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (unlocked) saw_unlock = 1'b1;
            if (!locked_out) break;
            lock_len++;
            kbus.key_valid = (i < 10) && (i % 2 == 0);
            kbus.key_code  = (i < 10) ? lock_keys[i/2] : 4'd0;
        end
        kbus.key_valid = 1'b0;
        check("t2_lock_len", lock_len, 32'd16);
        check("t2_no_unlock", {31'd0, saw_unlock}, 32'd0);
        check("t2_attempts_back", {28'd0, attempts_left}, 32'd3);
        check("t2_count_clean", {28'd0, digit_count}, 32'd0);

        // Overflowing entry is rejected; CLEAR restarts the entry.
        press_code(32'h12345, 5);
        check("t3_count_sat", {28'd0, digit_count}, 32'd5);
        press(4'd6);
        check("t3_count_hold", {28'd0, digit_count}, 32'd5);
        press(K_ENTER);
        tick();
        check("t3_ovf_fail", {31'd0, fail_pulse}, 32'd1);
        check("t3_ovf_att", {28'd0, attempts_left}, 32'd2);
        press_code(32'h12, 2);
        press(K_CLEAR);
        check("t3_clear", {28'd0, digit_count}, 32'd0);
        press(4'd15);
        check("t3_ignored", {28'd0, digit_count}, 32'd0);
        press_code(32'h1234, 4);
        press(K_ENTER);
        tick();
        check("t3_unlocked", {31'd0, unlocked}, 32'd1);
        check("t3_att_clear", {28'd0, attempts_left}, 32'd3);
        press(K_ENTER);
        check("t3_relock", {31'd0, unlocked}, 32'd0);

        // Admin login then reprogram to 9876.
        press(K_MODE);
        check("t4_pm_auth", {31'd0, prog_mode}, 32'd1);
        press_code(32'h6666, 4);
        check("t4_pm_digits", {31'd0, prog_mode}, 32'd1);
        press(K_ENTER);
        tick();
        check("t4_pm_new", {31'd0, prog_mode}, 32'd1);
        check("t4_no_fail", {31'd0, fail_pulse}, 32'd0);
        press_code(32'h9876, 4);
        press(K_ENTER);
        check("t4_updated", {31'd0, code_updated}, 32'd1);
        check("t4_pm_off", {31'd0, prog_mode}, 32'd0);
        tick();
        check("t4_updated_once", {31'd0, code_updated}, 32'd0);
        press_code(32'h1234, 4);
        press(K_ENTER);
        tick();
        check("t4_old_fail", {31'd0, fail_pulse}, 32'd1);
        press_code(32'h9876, 4);
        press(K_ENTER);
        tick();
        check("t4_new_open", {31'd0, unlocked}, 32'd1);
        press(K_ENTER);

        // Reset after reprogramming restores 1234.
        press_code(32'h98, 2);
        do_reset("t6_rst_prog");
        press_code(32'h1234, 4);
        press(K_ENTER);
        tick();
        check("t6_open_after_rst", {31'd0, unlocked}, 32'd1);
        tick();
        tick();
        do_reset("t6_rst_open");
        press_code(32'h1234, 4);
        press(K_ENTER);
        tick();
        check("t6_open_again", {31'd0, unlocked}, 32'd1);
        press(K_ENTER);

        // Short new code is rejected without counting; wrong admin code counts.
        press(K_MODE);
        press_code(32'h6666, 4);
        press(K_ENTER);
        tick();
        press_code(32'h98, 2);
        press(K_ENTER);
        check("t5_short_fail", {31'd0, fail_pulse}, 32'd1);
        check("t5_short_upd", {31'd0, code_updated}, 32'd0);
        check("t5_short_att", {28'd0, attempts_left}, 32'd3);
        press_code(32'h1234, 4);
        press(K_ENTER);
        tick();
        check("t5_code_kept", {31'd0, unlocked}, 32'd1);
        press(K_ENTER);
        press(K_MODE);
        press_code(32'h1111, 4);
        press(K_ENTER);
        tick();
        check("t5_admin_fail", {31'd0, fail_pulse}, 32'd1);
        check("t5_admin_att", {28'd0, attempts_left}, 32'd2);
        check("t5_admin_pm", {31'd0, prog_mode}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
